// File: rtl/adder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_pkg : shared types and constants for the byte-serial adder |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ripple_carry_adder : WIDTH-bit ripple-carry adder, combinational |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/byte_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_serial_adder : multi-byte add/sub, one byte slice per cycle |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module byte_serial_adder
    import adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic                     cin,
    input  logic [BYTE_W*NBYTES-1:0] a_in,
    input  logic [BYTE_W*NBYTES-1:0] b_in,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] sum_out,
    output logic                     cout_out
);

    localparam int            W      = BYTE_W * NBYTES;
    localparam int            CW     = $clog2(NBYTES);
    localparam logic [CW-1:0] c_LAST = CW'(NBYTES - 1);

    bsa_state_t     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_acc;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_sum_byte;
    logic              w_cout;
    logic [W-1:0]      w_acc_next;

    assign w_a_byte = r_a[r_cnt*BYTE_W +: BYTE_W];
    assign w_b_byte = r_b[r_cnt*BYTE_W +: BYTE_W];

    ripple_carry_adder #(
        .WIDTH (BYTE_W)
    ) u_rca (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_sum_byte),
        .o_cout (w_cout)
    );

    // Accumulator with the current byte slice merged in, so the final
    // byte can be published to sum_out on the same edge it is computed.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[r_cnt*BYTE_W +: BYTE_W] = w_sum_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1
                        r_a     <= a_in;
                        r_b     <= op_sub ? ~b_in : b_in;
                        r_carry <= op_sub | cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        sum_out  <= w_acc_next;
                        cout_out <= w_cout;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        ready    <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_byte_serial_adder : directed and random checks, NBYTES=4      |
// | Revision             : 1.0                                       |
// +------------------------------------------------------------------+
module tb_byte_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic        cin;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] sum_out;
    logic        cout_out;

    int checks = 0;
    int errors = 0;

    byte_serial_adder #(
        .NBYTES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .cin      (cin),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op from a point #1 after an edge; returns result and the
    // number of edges from accept to done (20 means no done was seen).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s,
                         output logic [31:0] sum, output logic co,
                         output int lat);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin    = c;
        op_sub = s;
        @(posedge clk); #1;
        start  = 1'b0;
        a_in   = $urandom;
        b_in   = $urandom;
        cin    = 1'($urandom);
        op_sub = 1'($urandom);
        lat    = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = sum_out;
        co  = cout_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sum_out, cout_out, done, busy, ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got sum=%h cout=%b done=%b busy=%b ready=%b, want 0 0 0 0 1",
                     sum_out, cout_out, done, busy, ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        logic [31:0] s;
        logic        co;
        int          lat;
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, s, co, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d edges, want 4", lat);
        end
        checks++;
        if ({co, s} !== {1'b0, 32'h0000_0100}) begin
            errors++;
            $display("FAIL add_basic: got cout=%b sum=%h, want 0 00000100", co, s);
        end
    endtask

    task automatic test_carry_ripple();
        logic [31:0] s;
        logic        co;
        int          lat;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b1, 32'h0000_0000} || lat !== 4) begin
            errors++;
            $display("FAIL carry_ripple: got cout=%b sum=%h lat=%0d, want 1 00000000 4", co, s, lat);
        end
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b0, 32'h2345_678A} || lat !== 4) begin
            errors++;
            $display("FAIL add_cin: got cout=%b sum=%h lat=%0d, want 0 2345678a 4", co, s, lat);
        end
    endtask

    task automatic test_sub();
        logic [31:0] s;
        logic        co;
        int          lat;
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, s, co, lat);
        checks++;
        if ({co, s} !== {1'b0, 32'hFFFF_FFFE} || lat !== 4) begin
            errors++;
            $display("FAIL sub_borrow: got cout=%b sum=%h lat=%0d, want 0 fffffffe 4", co, s, lat);
        end
        // cin must be ignored for subtraction
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, s, co, lat);
        checks++;
        if ({co, s} !== {1'b1, 32'h0000_0002} || lat !== 4) begin
            errors++;
            $display("FAIL sub_noborrow: got cout=%b sum=%h lat=%0d, want 1 00000002 4", co, s, lat);
        end
    endtask

    task automatic test_busy_ignore();
        @(posedge clk); #1;
        start = 1'b1; a_in = 32'h0000_0010; b_in = 32'h0000_0020; cin = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D; cin = 1'b1; op_sub = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy, ready, done} !== 3'b100) begin
                errors++;
                $display("FAIL busy_flags: cycle %0d got busy=%b ready=%b done=%b, want 1 0 0",
                         i, busy, ready, done);
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, cout_out, sum_out} !== {1'b1, 1'b0, 32'h0000_0030}) begin
            errors++;
            $display("FAIL busy_ignore: got done=%b cout=%b sum=%h, want 1 0 00000030",
                     done, cout_out, sum_out);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, ready, sum_out} !== {3'b001, 32'h0000_0030}) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b ready=%b sum=%h, want 0 0 1 00000030",
                     done, busy, ready, sum_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        logic        co;
        int          lat;
        do_op(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b0, 32'h0000_1234} || lat !== 4) begin
            errors++;
            $display("FAIL b2b_first: got cout=%b sum=%h lat=%0d, want 0 00001234 4", co, s, lat);
        end
        // Issued in the DONE cycle: second done is lat+1 edges after the first
        do_op(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b1, 32'h0000_0001} || lat + 1 !== 5) begin
            errors++;
            $display("FAIL b2b_second: got cout=%b sum=%h gap=%0d, want 1 00000001 5", co, s, lat + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s;
        logic        co;
        int          lat;
        int          seen;
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b1, 32'h0000_0001}) begin
            errors++;
            $display("FAIL pre_abort: got cout=%b sum=%h, want 1 00000001", co, s);
        end
        @(posedge clk); #1;
        start = 1'b1; a_in = 32'h0101_0101; b_in = 32'h0202_0202; cin = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({sum_out, cout_out, done, busy, ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_state: got sum=%h cout=%b done=%b busy=%b ready=%b, want 0 0 0 0 1",
                     sum_out, cout_out, done, busy, ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
        end
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, s, co, lat);
        checks++;
        if ({co, s} !== {1'b0, 32'h0000_0002} || lat !== 4) begin
            errors++;
            $display("FAIL post_abort: got cout=%b sum=%h lat=%0d, want 0 00000002 4", co, s, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, s;
        logic        c, sb, co;
        logic [32:0] exp;
        int          lat, gap;
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                if (g == 0) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_pulse: op %0d done=%b one cycle after done, want 0", n, done);
                    end
                end
            end
            a  = $urandom;
            b  = $urandom;
            c  = 1'($urandom);
            sb = 1'($urandom);
            exp = sb ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b} + {32'd0, c});
            do_op(a, b, c, sb, s, co, lat);
            checks++;
            if ({co, s} !== exp || lat !== 4) begin
                errors++;
                $display("FAIL rand_op: op %0d a=%h b=%h cin=%b sub=%b got %h lat=%0d, want %h lat=4",
                         n, a, b, c, sb, {co, s}, lat, exp);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        cin    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_sub();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
